key_debounce_multi: RTL and testbench

//  Parametrised multi-channel debouncer for active-low mechanical keys.
//  - Per-channel sync, tick-based stable counter and edge detection.
//  - Outputs a debounced pressed level, 1-cycle press/release pulses and an optional long-press pulse.
//  - Sits between the board key pins and the UI/control FSMs.
//  - One shared prescaler drives all channels.

---
 rtl/key_debounce_multi.sv | 123 ++++++++++++
 tb/tb_key_debounce_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: multi-channel debouncer for active-low keys with one shared tick prescaler.
// Define LONG_PRESS_EN to build the per-channel long-press counters; `release` is a reserved word, so that port is key_release.
module key_debounce_lane #(
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 50
) (
   input  logic clk,
   input  logic rstn,
   input  logic tick,
   input  logic key,
   output logic level,
   output logic press,
   output logic rel,
   output logic long_press
);
   localparam int DW = $clog2(STABLE_TICKS);
   localparam logic [DW-1:0] DMAX = DW'(STABLE_TICKS - 1);

   logic          pin_q, sync_m, sync, db, db_q;
   logic [DW-1:0] dcnt;

   assign level = ~db;

   // Pin capture flop ahead of the 2-flop synchronizer; all reset to released (1).
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pin_q  <= 1'b1;
         sync_m <= 1'b1;
         sync   <= 1'b1;
         db     <= 1'b1;
         db_q   <= 1'b1;
         dcnt   <= '0;
         press  <= 1'b0;
         rel    <= 1'b0;
      end else begin
         {sync, sync_m, pin_q} <= {sync_m, pin_q, key};
         db_q <= db;
         if (sync == db)
            dcnt <= '0;
         else if (tick) begin
            if (dcnt == DMAX) begin
               db   <= sync;
               dcnt <= '0;
            end else
               dcnt <= dcnt + 1'b1;
         end
         press <= db_q & ~db;
         rel   <= ~db_q & db;
      end
   end

`ifdef LONG_PRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);
   localparam logic [LW-1:0] LMAX = LW'(LONG_TICKS);

   logic [LW-1:0] lcnt;

   // Saturating hold counter: pulse only on the step into LMAX, so no repeat while held.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lcnt       <= '0;
         long_press <= 1'b0;
      end else begin
         long_press <= 1'b0;
         if (db)
            lcnt <= '0;
         else if (tick && lcnt != LMAX) begin
            lcnt       <= lcnt + 1'b1;
            long_press <= (lcnt == LMAX - 1'b1);
         end
      end
   end
`else
   assign long_press = 1'b0;
`endif
endmodule

module key_debounce_multi #(
   parameter int KEY_W        = 4,
   parameter int TICK_DIV     = 1000000,
   parameter int STABLE_TICKS = 4,
   parameter int LONG_TICKS   = 50
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [KEY_W-1:0] key,
   output logic [KEY_W-1:0] key_level,
   output logic [KEY_W-1:0] press,
   output logic [KEY_W-1:0] key_release,
   output logic [KEY_W-1:0] long_press
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [TW-1:0] tcnt;
   logic          tick;

   assign tick = (tcnt == TW'(TICK_DIV - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         tcnt <= '0;
      else if (tick)
         tcnt <= '0;
      else
         tcnt <= tcnt + 1'b1;
   end

   for (genvar i = 0; i < KEY_W; i++) begin : g_lane
      key_debounce_lane #(
         .STABLE_TICKS(STABLE_TICKS),
         .LONG_TICKS  (LONG_TICKS)
      ) u_lane (
         .clk       (clk),
         .rstn      (rstn),
         .tick      (tick),
         .key       (key[i]),
         .level     (key_level[i]),
         .press     (press[i]),
         .rel       (key_release[i]),
         .long_press(long_press[i])
      );
   end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Scoreboard bench for key_debounce_multi (KEY_W=4, TICK_DIV=1, STABLE_TICKS=4, LONG_TICKS=16).
// Long-press expectations are only queued when LONG_PRESS_EN is defined.
module tb_key_debounce_multi;
   logic       clk  = 1'b0;
   logic       rstn = 1'b1;
   logic [3:0] key  = 4'hF;
   logic [3:0] key_level, press, key_release, long_press;

   key_debounce_multi #(
      .KEY_W(4), .TICK_DIV(1), .STABLE_TICKS(4), .LONG_TICKS(16)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .key        (key),
      .key_level  (key_level),
      .press      (press),
      .key_release(key_release),
      .long_press (long_press)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int       cyc;
      logic [3:0] lvl, pr, rl, lp;
   } ev_t;

   ev_t q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic push(input int c, input logic [3:0] l, input logic [3:0] pr,
                       input logic [3:0] rl, input logic [3:0] lp);
      ev_t e;
      e.cyc = c; e.lvl = l; e.pr = pr; e.rl = rl; e.lp = lp;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: fires on any pulse or key_level change and checks it against the queue head.
   initial begin
      logic [3:0] prev;
      ev_t        e;
      prev = 4'h0;
      forever begin
         @(posedge clk);
         #1;
         if (!rstn) begin
            n_cmp++;
            if ({key_level, press, key_release, long_press} !== 16'h0) begin
               n_bad++;
               $display("FAIL reset_state: cyc=%0d got lvl=%h pr=%h rl=%h lp=%h, want all 0",
                        cyc, key_level, press, key_release, long_press);
            end
            prev = 4'h0;
         end else begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               e = q.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_event: want at cyc=%0d lvl=%h pr=%h rl=%h lp=%h, nothing by cyc=%0d",
                        e.cyc, e.lvl, e.pr, e.rl, e.lp, cyc);
            end
            if (press != 0 || key_release != 0 || long_press != 0 || key_level != prev) begin
               n_cmp++;
               if (q.size() > 0 && q[0].cyc == cyc) begin
                  e = q.pop_front();
                  if (key_level !== e.lvl || press !== e.pr || key_release !== e.rl || long_press !== e.lp) begin
                     n_bad++;
                     $display("FAIL event: cyc=%0d got lvl=%h pr=%h rl=%h lp=%h, want lvl=%h pr=%h rl=%h lp=%h",
                              cyc, key_level, press, key_release, long_press, e.lvl, e.pr, e.rl, e.lp);
                  end
               end else begin
                  n_bad++;
                  $display("FAIL unexpected_event: cyc=%0d got lvl=%h pr=%h rl=%h lp=%h, want no change",
                           cyc, key_level, press, key_release, long_press);
               end
            end
            prev = key_level;
         end
      end
   end

   // Stimulus: key changes at a negedge with cyc=c; edge k after that shows up as cyc c+k+1.
   initial begin
      int c;
      // Reset with keys released, then idle: nothing may move.
      rstn = 1'b0;
      key  = 4'hF;
      wait_cyc(5);
      rstn = 1'b1;
      wait_cyc(50);

      // key[0] press: level after edge 6, press pulse after edge 7.
      c = cyc; key = 4'hE;
      push(c + 7, 4'h1, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h1, 4'h1, 4'h0, 4'h0);
      wait_cyc(10);

      // key[0] release.
      c = cyc; key = 4'hF;
      push(c + 7, 4'h0, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h0, 4'h0, 4'h1, 4'h0);
      wait_cyc(12);

      // key[1] low for 3 cycles: rejected as a glitch.
      key = 4'hD;
      wait_cyc(3);
      key = 4'hF;
      wait_cyc(12);

      // key[1] low for 4 cycles: just enough to be accepted, then released.
      c = cyc; key = 4'hD;
      push(c + 7,  4'h2, 4'h0, 4'h0, 4'h0);
      push(c + 8,  4'h2, 4'h2, 4'h0, 4'h0);
      wait_cyc(4);
      key = 4'hF;
      push(c + 11, 4'h0, 4'h0, 4'h0, 4'h0);
      push(c + 12, 4'h0, 4'h0, 4'h2, 4'h0);
      wait_cyc(14);

      // All keys together.
      c = cyc; key = 4'h0;
      push(c + 7, 4'hF, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'hF, 4'hF, 4'h0, 4'h0);
      wait_cyc(8);
      c = cyc; key = 4'hF;
      push(c + 7, 4'h0, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h0, 4'h0, 4'hF, 4'h0);
      wait_cyc(12);

      // key[2] held 40 cycles: long press 16 ticks after level rises.
      c = cyc; key = 4'hB;
      push(c + 7, 4'h4, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h4, 4'h4, 4'h0, 4'h0);
`ifdef LONG_PRESS_EN
      push(c + 23, 4'h4, 4'h0, 4'h0, 4'h4);
`endif
      wait_cyc(40);
      c = cyc; key = 4'hF;
      push(c + 7, 4'h0, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h0, 4'h0, 4'h4, 4'h0);
      wait_cyc(12);

      // key[2] held across a reset pulse: fresh debounce and press afterwards.
      c = cyc; key = 4'hB;
      push(c + 7, 4'h4, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h4, 4'h4, 4'h0, 4'h0);
      wait_cyc(12);
      rstn = 1'b0;
      wait_cyc(3);
      rstn = 1'b1;
      c = cyc;
      push(c + 7, 4'h4, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h4, 4'h4, 4'h0, 4'h0);
`ifdef LONG_PRESS_EN
      push(c + 23, 4'h4, 4'h0, 4'h0, 4'h4);
`endif
      wait_cyc(30);
      c = cyc; key = 4'hF;
      push(c + 7, 4'h0, 4'h0, 4'h0, 4'h0);
      push(c + 8, 4'h0, 4'h0, 4'h4, 4'h0);
      wait_cyc(15);

      n_cmp++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_events: got %0d still queued, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
